mem_wb_pipe_reg: RTL

//  Parametrised MEM->WB pipeline register for the MIPS datapath, replacing the combinational-delay latch.

---
 rtl/mem_wb_pkg.sv | 29 ++
 rtl/pipe_skid_buf.sv | 64 ++++++
 rtl/mem_wb_pipe_reg.sv | 84 ++++++++
 3 files changed

// File: rtl/mem_wb_pkg.sv
// Shared MEM->WB definitions: write-back control bit positions, entry layout, regwrite gating.
package mem_wb_pkg;

    localparam int unsigned WB_REGWRITE_BIT = 1;
    localparam int unsigned WB_MEMTOREG_BIT = 0;
    localparam int unsigned WB_CTRL_W       = 2;
    localparam int unsigned WB_DEF_DATA_W   = 32;
    localparam int unsigned WB_DEF_REG_AW   = 5;

    typedef logic [WB_CTRL_W-1:0] wb_ctrl_t;

    // Default-width entry; parametrised users redeclare the same field order at their width.
    typedef struct packed {
        wb_ctrl_t                 ctrl;
        logic [WB_DEF_DATA_W-1:0] read_data;
        logic [WB_DEF_DATA_W-1:0] alu_result;
        logic [WB_DEF_REG_AW-1:0] write_reg;
    } mem_wb_entry_t;

    function automatic logic gate_regwrite(
        input logic     valid,
        input wb_ctrl_t ctrl,
        input logic     zero_dest,
        input logic     suppress_zero
    );
        return valid & ctrl[WB_REGWRITE_BIT] & ~(suppress_zero & zero_dest);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer; in_ready is registered (no path from out_ready).
module pipe_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             push;
    logic             pop;

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign push      = in_valid & in_ready;
    assign pop       = main_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            // Data registers are left untouched so outputs hold their last value.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= push;
                if (push) begin
                    skid_data <= in_data;
                end
            end else begin
                main_valid <= push;
                if (push) begin
                    main_data <= in_data;
                end
            end
        end else if (push) begin
            if (!main_valid) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end
    end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: skid buffer plus wb_data mux and reg-0 write suppression.
// Optional EX forwarding outputs are enabled by defining MEM_WB_FWD_EN.
module mem_wb_pipe_reg #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned ZERO_SUPP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_ctrl_wb,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [REG_AW-1:0] in_write_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              regwrite,
    output logic              memtoreg,
    output logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [REG_AW-1:0] mem_write_reg,
    output logic [DATA_W-1:0] wb_data
`ifdef MEM_WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    import mem_wb_pkg::*;

    typedef struct packed {
        wb_ctrl_t          ctrl;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_result;
        logic [REG_AW-1:0] write_reg;
    } entry_t;

    localparam logic SUPPRESS_ZERO = (ZERO_SUPP != 0);

    entry_t in_entry;
    entry_t out_entry;
    logic   zero_dest;

    assign in_entry = '{
        ctrl:       in_ctrl_wb,
        read_data:  in_read_data,
        alu_result: in_alu_result,
        write_reg:  in_write_reg
    };

    pipe_skid_buf #(
        .WIDTH($bits(entry_t))
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign memtoreg       = out_entry.ctrl[WB_MEMTOREG_BIT];
    assign read_data      = out_entry.read_data;
    assign mem_alu_result = out_entry.alu_result;
    assign mem_write_reg  = out_entry.write_reg;
    assign zero_dest      = (out_entry.write_reg == '0);
    assign regwrite       = gate_regwrite(out_valid, out_entry.ctrl, zero_dest, SUPPRESS_ZERO);
    assign wb_data        = memtoreg ? out_entry.read_data : out_entry.alu_result;

`ifdef MEM_WB_FWD_EN
    // regwrite already folds in out_valid and reg-0 suppression.
    assign fwd_valid = regwrite;
    assign fwd_reg   = out_entry.write_reg;
    assign fwd_data  = wb_data;
`endif

endmodule
